// File: rtl/pipe_stall_ctrl_if.sv
// Control bundle between the stall/flush sequencer and the pipeline:
// hazard and memory-wait inputs, per-stage enables and debug counters.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Hazard;
    logic             BranchTaken;
    logic             ImemBusy;
    logic             DmemBusy;
    logic             PCWrite;
    logic             IF_IDWrite;
    logic             IF_IDFlush;
    logic             ID_EXFlush;
    logic             EX_MEMWrite;
    logic             MEM_WBWrite;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    // The pipeline side raises events and consumes the stage controls
    modport master (
        output Hazard, BranchTaken, ImemBusy, DmemBusy,
        input  PCWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush,
        input  EX_MEMWrite, MEM_WBWrite, StallCnt, FlushCnt
    );

    modport slave (
        input  Hazard, BranchTaken, ImemBusy, DmemBusy,
        output PCWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush,
        output EX_MEMWrite, MEM_WBWrite, StallCnt, FlushCnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, redirect
// and memory-wait events into per-stage controls, with saturating counters.
module pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input logic                 CLK,
    input logic                 RST_N,
    pipe_stall_ctrl_if.slave    bus
);
    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Priority decode: memory freeze, redirect, load-use bubble, fetch wait,
    // then the deferred discard of a fetch that was in flight at a redirect.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        state_next   = state;
        if (!RST_N) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_next   = RUN;
        end else if (bus.DmemBusy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (bus.BranchTaken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = bus.ImemBusy ? SQUASH : RUN;
        end else if (bus.Hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.ImemBusy) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
        end else if (state == SQUASH) begin
            if_id_flush = 1'b1;
            state_next  = RUN;
        end
    end

    // Counters see the decoded controls of the same cycle and stop at all-ones
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (!pc_write && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((if_id_flush || id_ex_flush) && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IF_IDWrite  = if_id_write;
    assign bus.IF_IDFlush  = if_id_flush;
    assign bus.ID_EXFlush  = id_ex_flush;
    assign bus.EX_MEMWrite = ex_mem_write;
    assign bus.MEM_WBWrite = mem_wb_write;
    assign bus.StallCnt    = stall_cnt;
    assign bus.FlushCnt    = flush_cnt;

    // A held IF/ID must not also be flushed, and the PC never runs ahead of IF/ID
    a_hold_no_flush: assert property (@(posedge CLK) disable iff (!RST_N)
        !if_id_write |-> !if_id_flush);
    a_pc_needs_ifid: assert property (@(posedge CLK) disable iff (!RST_N)
        pc_write |-> if_id_write);
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: priority decode, squash tracking,
// reset behaviour and counter saturation on a narrow-counter instance.
module tb_pipe_stall_ctrl;
    // Control vector order: PCWrite, IF_IDWrite, IF_IDFlush, ID_EXFlush, EX_MEMWrite, MEM_WBWrite
    localparam logic [5:0] V_RESET  = 6'b001100;
    localparam logic [5:0] V_NORMAL = 6'b110011;
    localparam logic [5:0] V_HAZARD = 6'b000111;
    localparam logic [5:0] V_BRANCH = 6'b111111;
    localparam logic [5:0] V_IMEM   = 6'b011011;
    localparam logic [5:0] V_FREEZE = 6'b000000;
    localparam logic [5:0] V_SQRET  = 6'b111011;

    logic CLK = 1'b0;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;
    int   expStall = 0;
    int   expFlush = 0;
    bit   countersValid = 1'b0;

    pipe_stall_ctrl_if #(.CNT_W(16)) bus ();
    pipe_stall_ctrl_if #(.CNT_W(4))  bus4 ();

    pipe_stall_ctrl #(.CNT_W(16)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus4)
    );

    always #5 CLK = ~CLK;

    logic [5:0] ctrlVec;
    logic [5:0] ctrlVec4;
    assign ctrlVec  = {bus.PCWrite, bus.IF_IDWrite, bus.IF_IDFlush,
                       bus.ID_EXFlush, bus.EX_MEMWrite, bus.MEM_WBWrite};
    assign ctrlVec4 = {bus4.PCWrite, bus4.IF_IDWrite, bus4.IF_IDFlush,
                       bus4.ID_EXFlush, bus4.EX_MEMWrite, bus4.MEM_WBWrite};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic b, input logic i, input logic d);
        bus.Hazard      = h;
        bus.BranchTaken = b;
        bus.ImemBusy    = i;
        bus.DmemBusy    = d;
        #2;
    endtask

    // One pipeline cycle: drive, check controls and counters, advance the model
    task automatic runCycle(input string tag, input logic rstN, input logic h,
                            input logic b, input logic i, input logic d,
                            input logic [5:0] expVec);
        RST_N = rstN;
        applyStimulus(h, b, i, d);
        checkOutput({tag, ".ctrl"}, 32'(ctrlVec), 32'(expVec));
        if (countersValid) begin
            checkOutput({tag, ".stall"}, 32'(bus.StallCnt), 32'(expStall));
            checkOutput({tag, ".flush"}, 32'(bus.FlushCnt), 32'(expFlush));
        end
        if (!rstN) begin
            expStall      = 0;
            expFlush      = 0;
            countersValid = 1'b1;
        end else begin
            if (!expVec[5]) expStall++;
            if (expVec[3] || expVec[2]) expFlush++;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        bus4.Hazard = 1'b0; bus4.BranchTaken = 1'b0;
        bus4.ImemBusy = 1'b0; bus4.DmemBusy = 1'b0;
        applyStimulus(0, 0, 0, 0);
        @(posedge CLK);
        #1;

        runCycle("rst_a", 0, 0, 0, 0, 0, V_RESET);
        runCycle("rst_b", 0, 0, 0, 0, 0, V_RESET);
        runCycle("idle0", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("hazard", 1, 1, 0, 0, 0, V_HAZARD);
        runCycle("after_hz", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("br_hz", 1, 1, 1, 0, 0, V_BRANCH);
        runCycle("after_br", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("br_imem", 1, 0, 1, 1, 0, V_BRANCH);
        runCycle("sq_wait1", 1, 0, 0, 1, 0, V_IMEM);
        runCycle("sq_wait2", 1, 0, 0, 1, 0, V_IMEM);
        runCycle("sq_ret", 1, 0, 0, 0, 0, V_SQRET);
        runCycle("post_sq", 1, 0, 0, 0, 0, V_NORMAL);

        for (int k = 0; k < 3; k++) runCycle("freeze", 1, 1, 1, 0, 1, V_FREEZE);
        runCycle("br_unfrz", 1, 0, 1, 0, 0, V_BRANCH);
        runCycle("post_frz", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("imem_run", 1, 0, 0, 1, 0, V_IMEM);
        runCycle("imem_done", 1, 0, 0, 0, 0, V_NORMAL);

        // A load-use bubble while squashing must not consume the pending discard
        runCycle("sqh_br", 1, 0, 1, 1, 0, V_BRANCH);
        runCycle("sqh_hz", 1, 1, 0, 0, 0, V_HAZARD);
        runCycle("sqh_ret", 1, 0, 0, 0, 0, V_SQRET);
        runCycle("sqh_post", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("sqb_br1", 1, 0, 1, 1, 0, V_BRANCH);
        runCycle("sqb_br2", 1, 0, 1, 1, 0, V_BRANCH);
        runCycle("sqb_ret", 1, 0, 0, 0, 0, V_SQRET);
        runCycle("sqb_post", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("sqf_br", 1, 0, 1, 1, 0, V_BRANCH);
        runCycle("sqf_frz", 1, 0, 0, 1, 1, V_FREEZE);
        runCycle("sqf_ret", 1, 0, 0, 0, 0, V_SQRET);
        runCycle("sqf_post", 1, 0, 0, 0, 0, V_NORMAL);

        runCycle("sqr_br", 1, 0, 1, 1, 0, V_BRANCH);
        runCycle("sqr_rst", 0, 0, 0, 0, 0, V_RESET);
        runCycle("sqr_post", 1, 0, 0, 0, 0, V_NORMAL);
        runCycle("sqr_idle", 1, 0, 0, 0, 0, V_NORMAL);

        // Narrow instance: clear, then hold Hazard long enough to saturate
        runCycle("sat_rst", 0, 0, 0, 0, 0, V_RESET);
        RST_N = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            bus4.Hazard = 1'b1;
            #2;
            if (k == 0) checkOutput("sat.ctrl", 32'(ctrlVec4), 32'(V_HAZARD));
            checkOutput($sformatf("sat.stall%0d", k), 32'(bus4.StallCnt), (k < 15) ? k : 15);
            checkOutput($sformatf("sat.flush%0d", k), 32'(bus4.FlushCnt), (k < 15) ? k : 15);
            @(posedge CLK);
            #1;
        end
        bus4.Hazard = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
